tirage_de: RTL and testbench
============================

// Module: tirage_de
// PURPOSE
//  Die roller: consumer side of the die-type selector. Captures the selected
//  bounds dMin/dMax on a roll request, draws a pseudo-random value in
//  [dMin, dMax] from a free-running LFSR and delivers it as binary plus 3 BCD
//  digits, with a one-cycle pret pulse. Feeds the result-display decoders.
// PARAMETERS
//  W        7        width of dMin/dMax/valeur (values 0..127)
//  LFSR_W   16       LFSR width; low 8 bits used as raw draw
//  SEED     16'hACE1 LFSR reset value (non-zero)
// PORTS
//  clk      in   1  single clock
//  rst      in   1  synchronous, active-high reset
//  lancer   in   1  roll button level, synchronous to clk
//  dMin     in   W  lower bound from selector
//  dMax     in   W  upper bound from selector
//  valeur   out  W  rolled value, binary
//  bcd0     out  4  units digit
//  bcd1     out  4  tens digit
//  bcd2     out  4  hundreds digit
//  occupe   out  1  roll in progress
//  pret     out  1  one-cycle pulse: new result on valeur/bcd*
//  erreur   out  1  last roll had dMax < dMin
// BEHAVIOUR
//  - Reset: valeur=0, bcd*=0, occupe=0, pret=0, erreur=0, LFSR=SEED, IDLE.
//  - LFSR: Galois x^16+x^14+x^13+x^11+1, steps every cycle, never all-zero.
//  - lancer registered; roll starts on rising edge (0->1) in IDLE only.
//    Edges while occupe=1 are ignored; held level never retriggers.
//  - FSM IDLE -> CAPT -> REDUC -> ADD -> CONV -> FIN -> IDLE.
//    CAPT: latch dMin/dMax; plage = dMax-dMin+1 (8 bit); r = lfsr[7:0];
//      if dMax<dMin: erreur=1, skip to ADD with r=0. Else erreur=0.
//    REDUC: while r >= plage: r -= plage (one subtraction/cycle, <=255 cyc).
//      Modulo bias accepted. plage=1 forces r=0.
//    ADD: valeur_int = dMin + r (fits in W since r <= dMax-dMin).
//    CONV: sequential double-dabble, exactly W cycles, start pulse/done.
//    FIN: valeur, bcd2..0 updated together; pret=1 this cycle only.
//  - occupe=1 from cycle after edge detection until FIN inclusive.
//  - Latency edge->pret: 1+1+k+1+W+1 cycles, k = reductions (0..255).
//  - Outputs hold last result between rolls; dMin/dMax changes mid-roll
//    have no effect (captured copy used).
//  - rst mid-roll: abort, reset values above, no pret emitted.
// CONFIGURATION
//  TIRAGE_ANIM_EN defined: while lancer=1 and IDLE/after FIN, valeur/bcd*
//    show (lfsr[7:0] mod-free low bits clipped: dMin + lfsr[3:0] if <=dMax
//    else dMin) refreshed every 2^20 cycles ("spinning die"); pret stays 0
//    during animation; final roll still starts on the rising edge and the
//    result is shown at FIN, then animation resumes only on a new press.
//  Not defined: outputs change only at FIN.
// STRUCTURE
//  Package de_pkg: W_VAL=7, LFSR_W, SEED, LFSR tap mask, FSM state encoding
//    (shared with the selector / display blocks).
//  Sub-module bin_vers_bcd: sequential double-dabble, ports clk, rst, start,
//    bin[W-1:0] -> bcd0/bcd1/bcd2, fin pulse; W cycles per conversion.
// TESTING
//  1 d6 (dMin=1,dMax=6), 1000 rolls -> every valeur in 1..6, all 6 seen,
//    bcd matches valeur, exactly one pret per press.
//  2 d100 (1,100), force LFSR low byte 8'hFF -> r=255 mod 100=55, valeur=56,
//    bcd2=0,bcd1=5,bcd0=6, latency 1+1+2+1+7+1=13 cycles.
//  3 dMin=dMax=4 -> valeur=4 every roll, k=0, latency 11 cycles.
//  4 dMin=9,dMax=3 -> erreur=1, valeur=9, pret pulses; next valid roll
//    clears erreur.
//  5 second lancer edge and dMax change during REDUC -> ignored, result in
//    captured range, single pret.
//  6 rst asserted during CONV -> next cycle all outputs 0, no pret; a new
//    press afterwards completes normally.

Source files
------------

// File: rtl/de_pkg.sv
`default_nettype none
// ============================================================================
// Package  : de_pkg
// Purpose  : Shared die constants, LFSR polynomial and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package de_pkg;

    localparam int          W_VAL     = 7;
    localparam int          LFSR_LEN  = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          R_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAPT  = 3'd1,
        ST_REDUC = 3'd2,
        ST_ADD   = 3'd3,
        ST_CONV  = 3'd4,
        ST_FIN   = 3'd5
    } etat_e;

    function automatic logic [11:0] bcd_de(input logic [W_VAL-1:0] v);
        logic [11:0] b;
        b = '0;
        for (int i = W_VAL - 1; i >= 0; i--) begin
            for (int d = 0; d < 3; d++) begin
                if (b[4*d +: 4] >= 4'd5) begin
                    b[4*d +: 4] = b[4*d +: 4] + 4'd3;
                end
            end
            b = {b[10:0], v[i]};
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_vers_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin_vers_bcd
// Purpose  : Sequential double-dabble, W cycles from start to the fin pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bin_vers_bcd
    import de_pkg::*;
#(
    parameter int W = W_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic [3:0]   bcd0,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd2,
    output logic         fin
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh_q;
    logic [11:0]   bcd_q;
    logic [CW-1:0] cnt_q;
    logic          actif_q;
    logic [11:0]   w_adj;

    always_comb begin
        w_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The load cycle already shifts in the MSB (digits are zero, so no adjust),
    // which keeps the whole conversion at exactly W cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            actif_q <= 1'b0;
        end else if (start) begin
            sh_q    <= bin << 1;
            bcd_q   <= {11'd0, bin[W-1]};
            cnt_q   <= CW'(W - 1);
            actif_q <= 1'b1;
        end else if (actif_q) begin
            if (cnt_q == '0) begin
                actif_q <= 1'b0;
            end else begin
                bcd_q <= 12'({w_adj, sh_q[W-1]});
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign fin  = actif_q && (cnt_q == '0);
    assign bcd0 = bcd_q[3:0];
    assign bcd1 = bcd_q[7:4];
    assign bcd2 = bcd_q[11:8];

endmodule
`default_nettype wire

// File: rtl/tirage_de.sv
`default_nettype none
// ============================================================================
// Module   : tirage_de
// Purpose  : Die roller - draws a value in [dMin, dMax] from a free-running
//            LFSR on a lancer rising edge, outputs binary + 3 BCD digits.
// Option   : TIRAGE_ANIM_EN enables the "spinning die" display while held.
// Revision : 1.0 - initial release
// ============================================================================
module tirage_de
    import de_pkg::*;
#(
    parameter int                W      = W_VAL,
    parameter int                LFSR_W = LFSR_LEN,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(LFSR_SEED)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lancer,
    input  logic [W-1:0] dMin,
    input  logic [W-1:0] dMax,
    output logic [W-1:0] valeur,
    output logic [3:0]   bcd0,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd2,
    output logic         occupe,
    output logic         pret,
    output logic         erreur
);

    localparam logic [LFSR_W-1:0] c_taps = LFSR_W'(LFSR_TAPS);

    etat_e             etat_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              lancer_q;
    logic              lancer_prec_q;
    logic [W-1:0]      dmin_q;
    logic [R_W-1:0]    plage_q;
    logic [R_W-1:0]    r_q;
    logic [W-1:0]      val_int_q;
    logic [W-1:0]      valeur_q;
    logic [11:0]       bcd_q;
    logic              occupe_q;
    logic              pret_q;
    logic              erreur_q;

    logic              w_front;
    logic              w_inverse;
    logic [R_W-1:0]    w_plage;
    logic [R_W-1:0]    w_brut;
    logic [R_W-1:0]    w_reste;
    logic [W-1:0]      w_somme;
    logic              w_conv_start;
    logic              w_conv_fin;
    logic [3:0]        w_bcd0;
    logic [3:0]        w_bcd1;
    logic [3:0]        w_bcd2;

    assign lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? c_taps : '0);
    assign w_front      = lancer_q & ~lancer_prec_q;
    assign w_inverse    = dMax < dMin;
    assign w_plage      = R_W'({1'b0, dMax} - {1'b0, dMin}) + R_W'(1);
    assign w_brut       = lfsr_q[R_W-1:0];
    assign w_reste      = r_q - plage_q;
    assign w_somme      = dmin_q + W'(r_q);
    assign w_conv_start = (etat_q == ST_ADD);

    bin_vers_bcd #(
        .W (W)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_conv_start),
        .bin   (w_somme),
        .bcd0  (w_bcd0),
        .bcd1  (w_bcd1),
        .bcd2  (w_bcd2),
        .fin   (w_conv_fin)
    );

`ifdef TIRAGE_ANIM_EN
    logic [19:0]  anim_div_q;
    logic         anim_ok_q;
    logic         w_tic;
    logic [W:0]   w_anim_somme;
    logic [W-1:0] w_anim;

    assign w_tic        = &anim_div_q;
    assign w_anim_somme = {1'b0, dMin} + (W+1)'(lfsr_q[3:0]);
    assign w_anim       = (w_anim_somme <= {1'b0, dMax}) ? w_anim_somme[W-1:0] : dMin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            etat_q        <= ST_IDLE;
            lfsr_q        <= SEED;
            lancer_q      <= 1'b0;
            lancer_prec_q <= 1'b0;
            dmin_q        <= '0;
            plage_q       <= '0;
            r_q           <= '0;
            val_int_q     <= '0;
            valeur_q      <= '0;
            bcd_q         <= '0;
            occupe_q      <= 1'b0;
            pret_q        <= 1'b0;
            erreur_q      <= 1'b0;
`ifdef TIRAGE_ANIM_EN
            anim_div_q    <= '0;
            anim_ok_q     <= 1'b0;
`endif
        end else begin
            lfsr_q        <= lfsr_d;
            lancer_q      <= lancer;
            lancer_prec_q <= lancer_q;
            pret_q        <= 1'b0;
`ifdef TIRAGE_ANIM_EN
            anim_div_q    <= anim_div_q + 20'd1;
            if (w_front && etat_q != ST_IDLE) begin
                anim_ok_q <= 1'b1;
            end
`endif
            case (etat_q)
                ST_IDLE: begin
                    if (w_front) begin
                        etat_q   <= ST_CAPT;
                        occupe_q <= 1'b1;
                    end
`ifdef TIRAGE_ANIM_EN
                    else if (lancer_q && anim_ok_q && w_tic) begin
                        valeur_q <= w_anim;
                        bcd_q    <= bcd_de(w_anim);
                    end
`endif
                end
                ST_CAPT: begin
                    dmin_q   <= dMin;
                    plage_q  <= w_plage;
                    erreur_q <= w_inverse;
                    // Inverted bounds and single-value ranges need no reduction.
                    if (w_inverse || w_plage == R_W'(1)) begin
                        r_q    <= '0;
                        etat_q <= ST_ADD;
                    end else begin
                        r_q    <= w_brut;
                        etat_q <= (w_brut >= w_plage) ? ST_REDUC : ST_ADD;
                    end
                end
                ST_REDUC: begin
                    r_q <= w_reste;
                    if (w_reste < plage_q) begin
                        etat_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    val_int_q <= w_somme;
                    etat_q    <= ST_CONV;
                end
                ST_CONV: begin
                    if (w_conv_fin) begin
                        valeur_q <= val_int_q;
                        bcd_q    <= {w_bcd2, w_bcd1, w_bcd0};
                        pret_q   <= 1'b1;
                        etat_q   <= ST_FIN;
`ifdef TIRAGE_ANIM_EN
                        anim_ok_q <= 1'b0;
`endif
                    end
                end
                ST_FIN: begin
                    occupe_q <= 1'b0;
                    etat_q   <= ST_IDLE;
                end
                default: begin
                    occupe_q <= 1'b0;
                    etat_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign valeur = valeur_q;
    assign bcd0   = bcd_q[3:0];
    assign bcd1   = bcd_q[7:4];
    assign bcd2   = bcd_q[11:8];
    assign occupe = occupe_q;
    assign pret   = pret_q;
    assign erreur = erreur_q;

endmodule
`default_nettype wire

// File: tb/tb_tirage_de.sv
`default_nettype none
// ============================================================================
// Module   : tb_tirage_de
// Purpose  : Randomised self-checking bench for tirage_de against a
//            mod/div reference of the die draw.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tirage_de;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lancer = 1'b0;
    logic [6:0] dMin = 7'd1;
    logic [6:0] dMax = 7'd6;
    logic [6:0] valeur;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic       occupe;
    logic       pret;
    logic       erreur;

    int n_chk = 0;
    int n_err = 0;

    tirage_de dut (
        .clk    (clk),
        .rst    (rst),
        .lancer (lancer),
        .dMin   (dMin),
        .dMax   (dMax),
        .valeur (valeur),
        .bcd0   (bcd0),
        .bcd1   (bcd1),
        .bcd2   (bcd2),
        .occupe (occupe),
        .pret   (pret),
        .erreur (erreur)
    );

    always #5 clk = ~clk;

    // x^16 + x^14 + x^13 + x^11 + 1, Galois form shifting right
    function automatic logic [15:0] pas(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : pas(m_lfsr);

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: plain roll, 1: re-press + dMax change mid-roll, 2: reset during CONV
    task automatic do_roll(input string tg, input int dmin, input int dmax,
                           input int want_raw, input int min_raw, input int mode,
                           output int val_out);
        int          raw, pv, pk, perr, plage, lat, npret, win;
        int          g_val, g_b0, g_b1, g_b2, g_err, g_occ;
        logic [15:0] l;
        bit          found;
        lancer = 1'b0;
        @(negedge clk);
        dMin = 7'(dmin);
        dMax = 7'(dmax);
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        found = 1'b0;
        raw   = 0;
        for (int t = 0; t < 6000; t++) begin
            l   = pas(pas(m_lfsr));
            raw = int'(l[7:0]);
            if ((want_raw < 0 || raw == want_raw) && raw >= min_raw) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            check({tg, "_raw_wait"}, 0, 1);
            val_out = -1;
            return;
        end
        perr = (dmax < dmin) ? 1 : 0;
        pv   = dmin;
        pk   = 0;
        if (perr == 0) begin
            plage = dmax - dmin + 1;
            if (plage > 1) begin
                pv = dmin + raw % plage;
                pk = raw / plage;
            end
        end
        lancer = 1'b1;
        lat = 0; npret = 0;
        g_val = -1; g_b0 = -1; g_b1 = -1; g_b2 = -1; g_err = -1; g_occ = -1;
        win = (mode == 1) ? 30 : 4;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (mode == 2 && n == 7) begin
                check({tg, "_valeur0"}, int'(valeur), 0);
                check({tg, "_bcd0"}, int'({bcd2, bcd1, bcd0}), 0);
                check({tg, "_occupe0"}, int'(occupe), 0);
                check({tg, "_erreur0"}, int'(erreur), 0);
                rst = 1'b0;
            end
            if (pret) begin
                npret++;
                if (lat == 0) begin
                    lat   = n;
                    g_val = int'(valeur);
                    g_b0  = int'(bcd0);
                    g_b1  = int'(bcd1);
                    g_b2  = int'(bcd2);
                    g_err = int'(erreur);
                    g_occ = int'(occupe);
                end
            end
            if (mode == 1 && n == 4) lancer = 1'b0;
            if (mode == 1 && n == 6) begin
                lancer = 1'b1;
                dMax   = 7'd100;
            end
            if (mode == 2 && n == 6) begin
                rst    = 1'b1;
                lancer = 1'b0;
            end
            if (mode == 2 && n >= 30) break;
            if (mode != 2 && lat != 0 && n >= lat + win) break;
        end
        dMax = 7'(dmax);
        if (mode == 2) begin
            check({tg, "_no_pret"}, npret, 0);
            val_out = -1;
        end else begin
            check({tg, "_latency"}, lat, 11 + pk);
            check({tg, "_npret"}, npret, 1);
            check({tg, "_valeur"}, g_val, pv);
            check({tg, "_bcd0"}, g_b0, pv % 10);
            check({tg, "_bcd1"}, g_b1, (pv / 10) % 10);
            check({tg, "_bcd2"}, g_b2, pv / 100);
            check({tg, "_erreur"}, g_err, perr);
            check({tg, "_occupe"}, g_occ, 1);
            val_out = g_val;
        end
        lancer = 1'b0;
    endtask

    initial begin
        int         v, a, b;
        logic [7:0] seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valeur", int'(valeur), 0);
        check("rst_bcd", int'({bcd2, bcd1, bcd0}), 0);
        check("rst_occupe", int'(occupe), 0);
        check("rst_pret", int'(pret), 0);
        check("rst_erreur", int'(erreur), 0);
        rst = 1'b0;

        seen = '0;
        for (int i = 0; i < 1000; i++) begin
            do_roll("d6", 1, 6, -1, 0, 0, v);
            if (v >= 0 && v < 8) seen[v] = 1'b1;
        end
        check("d6_all_seen", int'(seen), 8'h7E);

        do_roll("d100", 1, 100, 255, 0, 0, v);
        check("d100_ff_valeur", v, 56);

        for (int i = 0; i < 3; i++) do_roll("d4", 4, 4, -1, 0, 0, v);

        do_roll("inverse", 9, 3, -1, 0, 0, v);
        check("inverse_valeur", v, 9);
        do_roll("apres_inv", 1, 6, -1, 0, 0, v);

        do_roll("perturb", 1, 6, -1, 60, 1, v);

        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) b = int'($urandom_range(0, 127));
            else                           b = int'($urandom_range(a, 127));
            do_roll("alea", a, b, -1, 0, 0, v);
        end

        do_roll("avant_rst", 4, 4, -1, 0, 0, v);
        do_roll("rst_conv", 4, 4, -1, 0, 2, v);
        do_roll("apres_rst", 2, 12, -1, 0, 0, v);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
